// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller.
// Sequences START, DATA, optional PARITY and STOP around an external
// serializer that supplies the data bits LSB-first. A watchdog counter
// ends the frame with a one-cycle frame_err pulse if the serializer never
// reports its last bit.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  frame_err
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit;
  logic             timeout;
  logic             accept;
  logic             par_bit;
  logic             par_en_q;

  assign accept   = (state == IDLE) && Data_Valid;
  assign last_bit = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

  // Next-state decode; ser_done only matters while in DATA.
  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      IDLE:    if (Data_Valid) state_nxt = START;
      START:   state_nxt = DATA;
      DATA: begin
        if (ser_done) begin
          state_nxt = par_en_q ? PARITY : STOP;
        end else if (last_bit) begin
          state_nxt = STOP;
          timeout   = 1'b1;
        end
      end
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Frame configuration captured at acceptance. PAR_TYP only influences
  // the parity bit, so its latched value lives inside par_bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
    end else if (accept) begin
      par_bit  <= (^P_DATA) ^ PAR_TYP;
      par_en_q <= PAR_EN;
    end
  end

  // DATA-cycle counter: cleared in START (the only way into DATA).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
    end else if (state == START) begin
      bit_cnt <= '0;
    end else if (state == DATA) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // Timeout flag, visible in the cycle after the final DATA cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_err <= 1'b0;
    else       frame_err <= timeout;
  end

  // Line mux from registered sources only.
  always_comb begin
    TX_OUT = 1'b1;
    case (state)
      IDLE:    TX_OUT = 1'b1;
      START:   TX_OUT = 1'b0;
      DATA:    TX_OUT = ser_data;
      PARITY:  TX_OUT = par_bit;
      STOP:    TX_OUT = 1'b1;
      default: TX_OUT = 1'b1;
    endcase
  end

  // Serializer enable and busy status.
  always_comb begin
    ser_en = (state == START) || ((state == DATA) && !ser_done);
    Busy   = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a table of per-cycle input and
// expected-output records plus hand-written reset sequences.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       ser_data;
  logic       ser_done;
  logic       ser_en;
  logic       TX_OUT;
  logic       Busy;
  logic       frame_err;

  // Serializer model controls: nd suppresses ser_done, fd forces it high.
  logic       nd;
  logic       fd;
  logic [8:0] sh;
  logic [3:0] scnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .ser_data  (ser_data),
    .ser_done  (ser_done),
    .ser_en    (ser_en),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy),
    .frame_err (frame_err)
  );

  // Serializer: loads {data, pad} on acceptance; the shift in START moves
  // D0 into place, so DATA cycle k presents D(k-1); done after 8 shifts.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sh   <= '0;
      scnt <= '0;
    end else if (Data_Valid && !Busy) begin
      sh   <= {P_DATA, 1'b0};
      scnt <= '0;
    end else if (ser_en) begin
      sh   <= sh >> 1;
      scnt <= scnt + 4'd1;
    end
  end

  assign ser_data = sh[0];
  assign ser_done = (!nd && (scnt == 4'd8)) || fd;

  typedef struct {
    logic       dv;
    logic [7:0] pdata;
    logic       pe;
    logic       pt;
    logic       nd;
    logic       fd;
    logic       tx;
    logic       busy;
    logic       sen;
    logic       fe;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic dv, input logic [7:0] d,
                              input logic pe, input logic pt, input logic ndv,
                              input logic tx, input logic busy,
                              input logic sen, input logic fe);
    vec_t v;
    v.dv = dv; v.pdata = d; v.pe = pe; v.pt = pt; v.nd = ndv; v.fd = 1'b0;
    v.tx = tx; v.busy = busy; v.sen = sen; v.fe = fe;
    return v;
  endfunction

  // One IDLE acceptance cycle followed by the full expected frame.
  task automatic add_frame(input logic [7:0] d, input logic pe, input logic pt,
                           input logic hold, input logic to);
    vecs.push_back(mk(1'b1, d, pe, pt, to, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(hold, d, pe, pt, to, 1'b0, 1'b1, 1'b1, 1'b0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(hold, d, pe, pt, to, d[i], 1'b1,
                        to ? 1'b1 : (i != 7), 1'b0));
    if (to) begin
      vecs.push_back(mk(hold, d, pe, pt, to, 1'b1, 1'b1, 1'b0, 1'b1));
    end else begin
      if (pe) vecs.push_back(mk(hold, d, pe, pt, to, (^d) ^ pt, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(hold, d, pe, pt, to, 1'b1, 1'b1, 1'b0, 1'b0));
    end
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++)
      vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic patch(input int idx, input logic dv, input logic [7:0] d,
                       input logic pe, input logic pt, input logic f);
    vec_t t;
    t = vecs[idx];
    t.dv = dv; t.pdata = d; t.pe = pe; t.pt = pt; t.fd = f;
    vecs[idx] = t;
  endtask

  task automatic chk(input string nm, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%b exp=%b", nm, idx, act, exp);
    end
  endtask

  // Entered #1 after a rising edge (or mid-cycle): drive, settle, compare.
  task automatic run_vecs(input int n);
    int lim;
    lim = (n < vecs.size()) ? n : vecs.size();
    for (int i = 0; i < lim; i++) begin
      Data_Valid = vecs[i].dv;
      P_DATA     = vecs[i].pdata;
      PAR_EN     = vecs[i].pe;
      PAR_TYP    = vecs[i].pt;
      nd         = vecs[i].nd;
      fd         = vecs[i].fd;
      #2;
      chk("tx",   i, TX_OUT,    vecs[i].tx);
      chk("busy", i, Busy,      vecs[i].busy);
      chk("sen",  i, ser_en,    vecs[i].sen);
      chk("ferr", i, frame_err, vecs[i].fe);
      @(posedge clk);
      #1;
    end
    vecs.delete();
  endtask

  initial begin
    int base;
    reset = 1'b1; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0;
    PAR_TYP = 1'b0; nd = 1'b0; fd = 1'b0;
    #2;
    chk("rst_tx",   0, TX_OUT,    1'b1);
    chk("rst_busy", 0, Busy,      1'b0);
    chk("rst_sen",  0, ser_en,    1'b0);
    chk("rst_ferr", 0, frame_err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 0xA5 even, odd, no parity.
    add_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    add_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    add_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    add_idle(1);
    // Data_Valid 0x3C pulsed at frame cycle 5 is ignored.
    base = vecs.size();
    add_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    patch(base + 5, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    add_idle(1);
    // PAR_TYP toggled during DATA of 0x01 (even parity -> 1).
    base = vecs.size();
    add_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 2; k < 10; k++) patch(base + k, 1'b0, 8'h01, 1'b1, k[0], 1'b0);
    // PAR_EN dropped mid-frame: parity still sent.
    base = vecs.size();
    add_frame(8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 11; k++) patch(base + k, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0);
    // Data_Valid held high: next frame one IDLE cycle after STOP.
    add_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b0);
    add_frame(8'h69, 1'b1, 1'b1, 1'b0, 1'b0);
    // ser_done forced high outside DATA has no effect.
    add_idle(1);
    patch(vecs.size() - 1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    base = vecs.size();
    add_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    patch(base + 0,  1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
    patch(base + 1,  1'b0, 8'h5A, 1'b1, 1'b0, 1'b1);
    patch(base + 10, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1);
    patch(base + 11, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1);
    add_idle(1);
    // Serializer never finishes: frame_err pulse, STOP, IDLE.
    add_frame(8'hB4, 1'b1, 1'b0, 1'b0, 1'b1);
    add_idle(2);
    run_vecs(100000);

    // Asynchronous reset during DATA cycle 4 of 0x5A (D3 = 1 on the line).
    add_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    run_vecs(5);
    Data_Valid = 1'b0;
    #2;
    chk("pre_rst_busy", 0, Busy,   1'b1);
    chk("pre_rst_sen",  0, ser_en, 1'b1);
    chk("pre_rst_tx",   0, TX_OUT, 1'b1);
    #1;
    chk("pre_rst_tx0",  0, TX_OUT, 1'b1);
    reset = 1'b1;
    #1;
    chk("arst_tx",   0, TX_OUT,    1'b1);
    chk("arst_busy", 0, Busy,      1'b0);
    chk("arst_sen",  0, ser_en,    1'b0);
    chk("arst_ferr", 0, frame_err, 1'b0);
    @(posedge clk);
    #1;
    chk("arst_hold_busy", 0, Busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    // First edge after release accepts 0xFF (odd parity -> 1).
    add_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    add_idle(2);
    run_vecs(100000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
